// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronise and deglitch the PS/2 lines,
// deserialise and check frames, fold 0xF0/0xE0 prefixes into flags.
module ps2_scancode_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TIMEOUT_W      = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic       scancode_valid,
   output logic       is_break,
   output logic       is_extended,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic                 clk_s1_q, clk_s2_q;
   logic                 dat_s1_q, dat_s2_q;
   logic [3:0]           flt_cnt_q, flt_cnt_d;
   logic                 filt_clk_q, filt_clk_d;
   logic                 filt_dly_q, filt_dly_d;
   state_t               state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 brk_pend_q, brk_pend_d;
   logic                 ext_pend_q, ext_pend_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [7:0]           code_q, code_d;
   logic                 valid_q, valid_d;
   logic                 brk_q, brk_d;
   logic                 ext_q, ext_d;
   logic                 err_q, err_d;
   logic                 fall;
   logic                 tmo_hit;
   logic                 good;

   // State register, including the two-flop synchronisers.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         flt_cnt_q  <= '0;
         filt_clk_q <= 1'b1;
         filt_dly_q <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         brk_pend_q <= 1'b0;
         ext_pend_q <= 1'b0;
         tmo_q      <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
         flt_cnt_q  <= flt_cnt_d;
         filt_clk_q <= filt_clk_d;
         filt_dly_q <= filt_dly_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         brk_pend_q <= brk_pend_d;
         ext_pend_q <= ext_pend_d;
         tmo_q      <= tmo_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
         err_q      <= err_d;
      end
   end

   // Clock deglitch filter, edge detect and frame watchdog.
   always_comb begin
      flt_cnt_d  = '0;
      filt_clk_d = filt_clk_q;
      filt_dly_d = filt_clk_q;
      if (clk_s2_q != filt_clk_q) begin
         if (flt_cnt_q == 4'(FILTER_LEN - 1)) begin
            filt_clk_d = clk_s2_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 4'd1;
         end
      end
   end

   assign fall    = filt_dly_q & ~filt_clk_q;
   assign tmo_hit = (state_q != IDLE) &&
                    (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   assign good    = dat_s2_q & (^{shift_q, par_q});

   always_comb begin
      tmo_d = tmo_q + TIMEOUT_W'(1);
      if (fall || tmo_hit || state_q == IDLE) begin
         tmo_d = '0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (tmo_hit) begin
         state_d = IDLE;
      end else if (fall) begin
         unique case (state_q)
            IDLE:    if (!dat_s2_q) state_d = DATA;
            DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and output logic.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      brk_pend_d = brk_pend_q;
      ext_pend_d = ext_pend_q;
      code_d     = code_q;
      brk_d      = brk_q;
      ext_d      = ext_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      if (tmo_hit) begin
         err_d      = 1'b1;
         brk_pend_d = 1'b0;
         ext_pend_d = 1'b0;
      end else if (fall) begin
         unique case (state_q)
            IDLE: bit_cnt_d = '0;
            DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
            PARITY: par_d = dat_s2_q;
            STOP: begin
               if (!good) begin
                  err_d      = 1'b1;
                  brk_pend_d = 1'b0;
                  ext_pend_d = 1'b0;
               end else if (shift_q == 8'hF0) begin
                  brk_pend_d = 1'b1;
               end else if (shift_q == 8'hE0) begin
                  ext_pend_d = 1'b1;
               end else begin
                  code_d     = shift_q;
                  brk_d      = brk_pend_q;
                  ext_d      = ext_pend_q;
                  valid_d    = 1'b1;
                  brk_pend_d = 1'b0;
                  ext_pend_d = 1'b0;
               end
            end
            default: bit_cnt_d = '0;
         endcase
      end
   end

   assign scancode       = code_q;
   assign scancode_valid = valid_q;
   assign is_break       = brk_q;
   assign is_extended    = ext_q;
   assign frame_err      = err_q;

endmodule
